// File: rtl/pixel_write_buffer.sv
// rtl/pixel_write_buffer.sv - clipped pixel FIFO draining to SRAM req/ack port; optional clipping via PIXEL_CLIP_EN
module pixel_write_buffer #(
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        pixel_valid,
  input  logic [18:0] pixel_addr,
  input  logic [7:0]  pixel_color,
  output logic        stop,
  output logic        mem_req,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_ack,
  input  logic        flush_req,
  output logic        flush_done,
  output logic        overflow,
  output logic [15:0] dropped_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] STOP_LVL = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [9:0]    X_LIM    = 10'(H_RES);
  localparam logic [8:0]    Y_LIM    = 9'(V_RES);
  localparam logic [18:0]   H_MUL    = 19'(H_RES);
`ifdef PIXEL_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  typedef enum logic {M_IDLE, M_REQ} mstate_t;
  typedef enum logic [1:0] {F_IDLE, F_DRAIN, F_DONE} fstate_t;

  logic [26:0]   fifo_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0] count, count_next;
  mstate_t       m_state, m_state_next;
  fstate_t       f_state, f_state_next;

  logic [9:0]  px;
  logic [8:0]  py;
  logic        clipped, push_try, push, pop, full, load_head;
  logic [18:0] lin_addr;
  logic [26:0] push_word, head_next;

  assign px        = pixel_addr[18:9];
  assign py        = pixel_addr[8:0];
  assign clipped   = CLIP_EN && ((px >= X_LIM) || (py >= Y_LIM));
  assign lin_addr  = ({10'd0, py} * H_MUL) + {9'd0, px};
  assign push_word = {lin_addr, pixel_color};

  assign full       = (count == FULL_LVL);
  assign pop        = (m_state == M_REQ) && mem_ack;
  assign push_try   = pixel_valid && !clipped;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push       = push_try && (!full || pop);
  assign count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  assign rd_next    = rd_ptr + AW'(1);

  assign mem_req    = (m_state == M_REQ);
  assign flush_done = (f_state == F_DONE);

  // The request register is loaded ahead of time, bypassing the array when
  // the entry being presented is written on this same edge.
  always_comb begin
    m_state_next = m_state;
    load_head    = 1'b0;
    head_next    = fifo_mem[rd_ptr];
    case (m_state)
      M_IDLE: begin
        if (count != '0 || push) begin
          m_state_next = M_REQ;
          load_head    = 1'b1;
          head_next    = (count != '0) ? fifo_mem[rd_ptr] : push_word;
        end
      end
      M_REQ: begin
        if (pop) begin
          if (count_next != '0) begin
            load_head = 1'b1;
            head_next = (count == ONE) ? push_word : fifo_mem[rd_next];
          end else begin
            m_state_next = M_IDLE;
          end
        end
      end
      default: m_state_next = M_IDLE;
    endcase
  end

  always_comb begin
    f_state_next = f_state;
    case (f_state)
      F_IDLE:  if (flush_req) f_state_next = F_DRAIN;
      F_DRAIN: if (count == '0 && m_state == M_IDLE && !push) f_state_next = F_DONE;
      F_DONE:  f_state_next = F_IDLE;
      default: f_state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      m_state       <= M_IDLE;
      f_state       <= F_IDLE;
      stop          <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      overflow      <= 1'b0;
      dropped_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_next;
      count   <= count_next;
      m_state <= m_state_next;
      f_state <= f_state_next;
      stop    <= (count_next >= STOP_LVL);
      if (load_head) {mem_addr, mem_data} <= head_next;
      if (push_try && !push) overflow <= 1'b1;
      if (pixel_valid && clipped && dropped_count != 16'hFFFF)
        dropped_count <= dropped_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb/tb_pixel_write_buffer.sv - self-checking bench for pixel_write_buffer against a queue-level model
module tb_pixel_write_buffer;
  localparam int DEPTH = 8;
  localparam int AF_MARGIN = 2;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [18:0] pixel_addr = '0;
  logic [7:0]  pixel_color = '0;
  logic        stop, mem_req, flush_done, overflow;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack = 1'b0;
  logic        flush_req = 1'b0;
  logic [15:0] dropped_count;

  pixel_write_buffer #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk(clk), .n_rst(n_rst), .pixel_valid(pixel_valid), .pixel_addr(pixel_addr),
    .pixel_color(pixel_color), .stop(stop), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .flush_req(flush_req), .flush_done(flush_done),
    .overflow(overflow), .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit clip_hit(input logic [18:0] a);
`ifdef PIXEL_CLIP_EN
    return (int'(a[18:9]) >= H_RES) || (int'(a[8:0]) >= V_RES);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [26:0] exp_word(input logic [18:0] a, input logic [7:0] c);
    int lin;
    lin = (int'(a[8:0]) * H_RES + int'(a[18:9])) % 524288;
    return {19'(lin), c};
  endfunction

  // Model: the queue holds every accepted, not yet written pixel; a request is
  // outstanding exactly while it is non-empty and always shows its head.
  logic [26:0] mq[$];
  logic [26:0] dut_writes[$];
  bit          m_ovf, m_drain, m_fd, m_pushed, model_live;
  logic [15:0] m_drop;
  int          m_sz0;

  always @(posedge clk) begin
    if (!n_rst) begin
      mq.delete();
      m_ovf = 0; m_drop = '0; m_drain = 0; m_fd = 0;
    end else begin
      m_sz0 = mq.size();
      m_pushed = 0;
      if (m_sz0 > 0 && mem_ack) void'(mq.pop_front());
      if (pixel_valid) begin
        if (clip_hit(pixel_addr)) begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else if (mq.size() < DEPTH) begin
          mq.push_back(exp_word(pixel_addr, pixel_color));
          m_pushed = 1;
        end else begin
          m_ovf = 1;
        end
      end
      if (m_drain && m_sz0 == 0 && !m_pushed) begin
        m_drain = 0; m_fd = 1;
      end else begin
        if (!m_drain && !m_fd && flush_req) m_drain = 1;
        m_fd = 0;
      end
    end
    model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("mem_req", mem_req, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("mem_addr", mem_addr, mq[0][26:8]);
        chk("mem_data", mem_data, mq[0][7:0]);
      end
      chk("stop", stop, (DEPTH - mq.size()) <= AF_MARGIN);
      chk("overflow", overflow, m_ovf);
      chk("dropped_count", dropped_count, m_drop);
      chk("flush_done", flush_done, m_fd);
      if (mem_req && mem_ack) dut_writes.push_back({mem_addr, mem_data});
    end
  end

  // SRAM responder: 0 = ack low, 1 = ack high, 2 = ack after two request cycles
  int ack_mode = 0;
  int lat = 0;
  always @(posedge clk) begin
    #2;
    case (ack_mode)
      0: begin mem_ack = 1'b0; lat = 0; end
      1: begin mem_ack = 1'b1; lat = 0; end
      default: begin
        if (mem_ack) begin
          mem_ack = 1'b0; lat = 0;
        end else if (mem_req) begin
          lat++;
          if (lat >= 2) mem_ack = 1'b1;
        end
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y, input logic [7:0] c);
    pixel_valid = 1'b1;
    pixel_addr  = {10'(x), 9'(y)};
    pixel_color = c;
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && mem_req; i++) tick();
    chk(name, mem_req, 1'b0);
  endtask

  int base, idle_cyc, done_cyc, pulses;

  initial begin
    // reset state
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stop", stop, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropped", dropped_count, 0);
    n_rst = 1'b1;
    tick();

    // single pixel
    push(3, 2, 8'hA5);
    chk("single_req", mem_req, 1);
    chk("single_addr", mem_addr, 1283);
    chk("single_data", mem_data, 8'hA5);
    ack_mode = 1;
    tick();
    ack_mode = 0;
    chk("single_req_fall", mem_req, 0);
    chk("single_nwrites", dut_writes.size(), 1);
    tick();

    // fill to full with ack low, then overflow
    base = dut_writes.size();
    for (int i = 0; i < 8; i++) begin
      push(i, 10, 8'h10 + 8'(i));
      chk("fill_stop", stop, i >= 5);
    end
    push(100, 100, 8'hFF);
    chk("ovf_set", overflow, 1);
    ack_mode = 1;
    tick();
    drain("fill_drain");
    ack_mode = 0;
    chk("fill_nwrites", dut_writes.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < dut_writes.size()) begin
        chk("fill_order_addr", dut_writes[base + i][26:8], 6400 + i);
        chk("fill_order_data", dut_writes[base + i][7:0], 8'h10 + i);
      end
    end

    // push and pop together while full
    do_reset();
    base = dut_writes.size();
    for (int i = 0; i < 8; i++) push(i, 1, 8'h20 + 8'(i));
    chk("full_stop", stop, 1);
    ack_mode = 1;
    push(50, 0, 8'h77);
    chk("pp_overflow", overflow, 0);
    chk("pp_stop", stop, 1);
    chk("pp_head_addr", mem_addr, 641);
    drain("pp_drain");
    ack_mode = 0;
    chk("pp_nwrites", dut_writes.size() - base, 9);
    if (dut_writes.size() - base == 9) begin
      chk("pp_first", dut_writes[base][26:8], 640);
      chk("pp_last_addr", dut_writes[base + 8][26:8], 50);
      chk("pp_last_data", dut_writes[base + 8][7:0], 8'h77);
    end

    // clipping
    do_reset();
    base = dut_writes.size();
    ack_mode = 1;
    push(640, 0, 8'h01);
    push(0, 480, 8'h02);
    push(1023, 511, 8'h03);
    push(639, 479, 8'h04);
    for (int i = 0; i < 5; i++) tick();
    ack_mode = 0;
`ifdef PIXEL_CLIP_EN
    chk("clip_dropped", dropped_count, 3);
    chk("clip_nwrites", dut_writes.size() - base, 1);
    if (dut_writes.size() > base) chk("clip_addr", dut_writes[base][26:8], 307199);
`else
    chk("noclip_dropped", dropped_count, 0);
    chk("noclip_nwrites", dut_writes.size() - base, 4);
    if (dut_writes.size() > base) chk("noclip_first", dut_writes[base][26:8], 640);
    if (dut_writes.size() - base == 4) chk("noclip_wrap", dut_writes[base + 2][26:8], 328063);
`endif

    // flush with ack latency
    do_reset();
    base = dut_writes.size();
    ack_mode = 2;
    push(1, 1, 8'h31);
    push(2, 1, 8'h32);
    push(3, 1, 8'h33);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    idle_cyc = -1; done_cyc = -1; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req && dut_writes.size() - base == 3 && idle_cyc < 0) idle_cyc = i;
      if (flush_done) begin pulses++; done_cyc = i; end
      tick();
    end
    ack_mode = 0;
    chk("flush_nwrites", dut_writes.size() - base, 3);
    chk("flush_pulses", pulses, 1);
    chk("flush_timing", done_cyc, idle_cyc + 1);

    // flush on empty idle block
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("eflush_n1", flush_done, 0);
    tick();
    chk("eflush_n2", flush_done, 1);
    tick();
    chk("eflush_n3", flush_done, 0);

    // reset mid-transaction
    for (int i = 0; i < 4; i++) push(i, 5, 8'h40 + 8'(i));
    chk("mid_req", mem_req, 1);
    n_rst = 1'b0;
    tick();
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_stop", stop, 0);
    chk("mid_rst_addr", mem_addr, 0);
    n_rst = 1'b1;
    base = dut_writes.size();
    ack_mode = 1;
    for (int i = 0; i < 6; i++) tick();
    ack_mode = 0;
    chk("mid_no_writes", dut_writes.size() - base, 0);
    chk("mid_idle", mem_req, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
